dac_serial_rx: RTL and testbench
================================

DAC_SERIAL_RX -- requirements
Module: dac_serial_rx

Interface
REQ-001 Parameter FRAME_BITS, default 24: bits per DAC programming frame.
REQ-002 Parameter CNT_W, default 16: width of the good-frame counter.
REQ-003 clk  input  1  single system clock; all logic is synchronous to its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 dac_ser_clk  input  1  DAC serial clock, asynchronous to clk.
REQ-006 dac_nsync  input  1  DAC frame sync, active low, asynchronous to clk.
REQ-007 dac_din  input  1  DAC serial data, MSB first, asynchronous to clk.
REQ-008 word_out  output  FRAME_BITS  last complete frame received.
REQ-009 word_valid  output  1  word_out holds an unconsumed frame.
REQ-010 word_ready  input  1  consumer accepts word_out when high together with word_valid.
REQ-011 frame_err  output  1  one-cycle pulse per frame closed with bit count not equal to FRAME_BITS.
REQ-012 overflow  output  1  sticky flag: a good frame was dropped because the holding register was full.
REQ-013 clr_overflow  input  1  synchronous clear of overflow.
REQ-014 frame_count  output  CNT_W  count of good frames received.

Function
REQ-015 Each of dac_ser_clk, dac_nsync and dac_din SHALL pass through a two-flop synchronizer before use.
REQ-016 A serial-clock falling edge SHALL be detected as synchronized sclk: previous 1, current 0.
REQ-017 The state machine SHALL have states IDLE and SHIFT.
REQ-018 IDLE -> SHIFT on synchronized nsync falling; the shift register and bit counter clear in the same cycle.
REQ-019 In SHIFT, each sclk falling edge SHALL shift synchronized din into the LSB and increment the bit counter, which saturates at FRAME_BITS+1.
REQ-020 SHIFT -> IDLE on synchronized nsync rising; an sclk falling edge in that same cycle SHALL be ignored.
REQ-021 At frame close with bit count == FRAME_BITS the frame is good; any other count (short, long or zero) SHALL pulse frame_err for one cycle and discard the data.
REQ-022 A good frame SHALL load word_out and assert word_valid on the clk edge following the close cycle, provided word_valid is low or word_ready is high in the close cycle.
REQ-023 Otherwise the good frame SHALL be dropped, word_out SHALL be retained, and overflow SHALL be set.
REQ-024 word_valid SHALL clear on a word_valid && word_ready handshake unless a new good frame loads in the same cycle.
REQ-025 frame_count SHALL increment on every good frame, including dropped ones, and wrap from all-ones to 0.
REQ-026 If clr_overflow and a new overflow event occur in the same cycle, overflow SHALL be set.
REQ-027 Correct capture requires the clk period to be at most 1/4 of the sclk period; faster sclk is outside the defined behaviour.
REQ-028 Latency from the dac_nsync pin rising to word_valid high SHALL be 4 clk cycles.

Reset
REQ-029 On reset_n low: state IDLE; word_out 0; word_valid, frame_err, overflow and frame_count 0; shift register and bit counter 0.
REQ-030 On reset_n low: synchronizers reset to sclk 1, nsync 1, din 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no frame_err; after release the receiver waits for the next nsync falling edge.

Structure
REQ-032 Package nimplus_pkg SHALL hold DAC_FRAME_BITS (24) and the rx_state_t enum {IDLE, SHIFT}.
REQ-033 Sub-module bit_sync, a two-flop synchronizer with a reset-value parameter, SHALL be instantiated three times.

Verification
REQ-034 Good frame: send 24 bits 0x3A5C01 with word_ready held 1 -> word_out=0x3A5C01, word_valid for 1 cycle, frame_count=1, no frame_err.
REQ-035 Short frame (23 bits) and long frame (25 bits) -> one frame_err pulse each, word_valid stays 0, frame_count unchanged.
REQ-036 Back-pressure: word_ready=0, send 0x000001 then 0x000002 -> word_out stays 0x000001, overflow=1, frame_count=2; clr_overflow pulse -> overflow=0.
REQ-037 Handshake/load collision: word_valid=1 and word_ready=1 in the close cycle of frame 0xFFFFFF -> word_out=0xFFFFFF, word_valid stays 1, overflow stays 0.
REQ-038 Reset mid-frame: assert reset_n low after 10 bits, release, then send 0x123456 -> only 0x123456 is delivered, frame_err never pulses.
REQ-039 Counter wrap: preload with CNT_W=4, send 16 good frames -> frame_count returns to 0.

Source files
------------

// File: rtl/nimplus_pkg.sv
// Shared constants and types for the DAC serial programming-port receiver.
package nimplus_pkg;

  // Bits in one DAC programming frame.
  localparam int unsigned DAC_FRAME_BITS = 24;

  // Receiver frame state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for one asynchronous input bit.
module bit_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; reset to the line's idle level so no false edge follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dac_serial_rx.sv
// Receives DAC programming frames (nsync/sclk/din, MSB first) in the clk domain and
// presents complete frames through a single-entry valid/ready holding register.
module dac_serial_rx
  import nimplus_pkg::*;
#(
  parameter int unsigned FRAME_BITS = DAC_FRAME_BITS,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dac_ser_clk,
  input  logic                  dac_nsync,
  input  logic                  dac_din,
  output logic [FRAME_BITS-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic [CNT_W-1:0]      frame_count
);

  // Counter must represent FRAME_BITS+1 so long frames remain distinguishable.
  localparam int unsigned BcntW = $clog2(FRAME_BITS + 2);
  localparam logic [BcntW-1:0] BcntFull = BcntW'(FRAME_BITS);
  localparam logic [BcntW-1:0] BcntSat  = BcntW'(FRAME_BITS + 1);

  logic sclk_s, nsync_s, din_s;
  logic sclk_prev_q, nsync_prev_q;
  logic sclk_fall, nsync_fall, nsync_rise;

  rx_state_t             state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [BcntW-1:0]      bcnt_q, bcnt_d;
  logic                  close_good_q, close_good_d;
  logic                  close_bad_q, close_bad_d;

  logic [FRAME_BITS-1:0] word_out_q, word_out_d;
  logic                  word_valid_q, word_valid_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_W-1:0]      frame_count_q, frame_count_d;
  logic                  load;

  bit_sync #(.RESET_VAL(1'b1)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dac_ser_clk),
    .q_o     (sclk_s)
  );

  bit_sync #(.RESET_VAL(1'b1)) u_sync_nsync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dac_nsync),
    .q_o     (nsync_s)
  );

  bit_sync #(.RESET_VAL(1'b0)) u_sync_din (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dac_din),
    .q_o     (din_s)
  );

  assign sclk_fall  = sclk_prev_q & ~sclk_s;
  assign nsync_fall = nsync_prev_q & ~nsync_s;
  assign nsync_rise = ~nsync_prev_q & nsync_s;

  // Previous synchronized samples for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q  <= 1'b1;
      nsync_prev_q <= 1'b1;
    end else begin
      sclk_prev_q  <= sclk_s;
      nsync_prev_q <= nsync_s;
    end
  end

  // Frame FSM: open on nsync fall, shift on sclk fall, judge bit count on nsync rise.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bcnt_d       = bcnt_q;
    close_good_d = 1'b0;
    close_bad_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (nsync_fall) begin
          state_d = SHIFT;
          shreg_d = '0;
          bcnt_d  = '0;
        end
      end
      SHIFT: begin
        if (nsync_rise) begin
          // An sclk fall coinciding with the close is deliberately dropped.
          state_d      = IDLE;
          close_good_d = (bcnt_q == BcntFull);
          close_bad_d  = (bcnt_q != BcntFull);
        end else if (sclk_fall) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], din_s};
          if (bcnt_q != BcntSat) begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register, overflow flag and good-frame counter, driven by the registered close.
  always_comb begin
    load          = close_good_q & (~word_valid_q | word_ready);
    word_out_d    = load ? shreg_q : word_out_q;
    word_valid_d  = word_valid_q;
    if (load) begin
      word_valid_d = 1'b1;
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
    // A new drop wins over a same-cycle clear.
    overflow_d    = (close_good_q & ~load) | (overflow_q & ~clr_overflow);
    frame_count_d = frame_count_q + CNT_W'(close_good_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bcnt_q        <= '0;
      close_good_q  <= 1'b0;
      close_bad_q   <= 1'b0;
      word_out_q    <= '0;
      word_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bcnt_q        <= bcnt_d;
      close_good_q  <= close_good_d;
      close_bad_q   <= close_bad_d;
      word_out_q    <= word_out_d;
      word_valid_q  <= word_valid_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign word_out    = word_out_q;
  assign word_valid  = word_valid_q;
  assign frame_err   = close_bad_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dac_serial_rx.sv
// Self-checking bench for dac_serial_rx with a frame-level reference model.
module tb_dac_serial_rx;

  localparam int unsigned FB = 24;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          dac_ser_clk = 1'b1;
  logic          dac_nsync = 1'b1;
  logic          dac_din = 1'b0;
  logic          word_ready = 1'b1;
  logic          clr_overflow = 1'b0;
  logic [FB-1:0] word_out;
  logic          word_valid;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] frame_count;

  always #5 clk = ~clk;

  dac_serial_rx #(
    .FRAME_BITS (FB),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dac_ser_clk  (dac_ser_clk),
    .dac_nsync    (dac_nsync),
    .dac_din      (dac_din),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .frame_count  (frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observed behaviour.
  int            err_seen = 0;
  logic [FB-1:0] got_q[$];

  // Reference model: one holding slot, sticky overflow, modulo frame count.
  logic          m_valid = 1'b0;
  logic          m_over  = 1'b0;
  logic [FB-1:0] m_word  = '0;
  int            m_count = 0;
  int            m_errs  = 0;
  logic [FB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err) err_seen++;
      if (word_valid && word_ready) got_q.push_back(word_out);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame close as seen by the consumer: handshake of the old word, then load or drop.
  task automatic model_close(input int nbits, input logic [31:0] data, input logic rdy);
    logic had_valid;
    had_valid = m_valid;
    if (m_valid && rdy) begin
      exp_q.push_back(m_word);
      m_valid = 1'b0;
    end
    if (nbits == FB) begin
      m_count = (m_count + 1) % (1 << CW);
      if (!had_valid || rdy) begin
        m_word  = data[FB-1:0];
        m_valid = 1'b1;
      end else begin
        m_over = 1'b1;
      end
    end else begin
      m_errs++;
    end
  endtask

  task automatic model_settle(input logic rdy);
    if (rdy && m_valid) begin
      exp_q.push_back(m_word);
      m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_word  = '0;
    m_count = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic compare_state(input string tag);
    check({tag, "_ndeliv"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_errs"}, 32'(err_seen), 32'(m_errs));
    check({tag, "_count"}, 32'(frame_count), 32'(m_count));
    check({tag, "_valid"}, 32'(word_valid), 32'(m_valid));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_over));
    if (m_valid) check({tag, "_held"}, 32'(word_out), 32'(m_word));
  endtask

  task automatic shift_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      dac_din = data[i];
      #20 dac_ser_clk = 1'b0;
      #40 dac_ser_clk = 1'b1;
      #20;
    end
  endtask

  // Sends one frame; lat is the edge count from the nsync rise to the new word or error (0 = none).
  task automatic send_frame(input logic [31:0] data, input int nbits, input logic collide,
                            output int lat);
    logic v_before;
    dac_nsync = 1'b0;
    #40;
    shift_bits(data, nbits);
    #40;
    @(posedge clk);
    #1;
    v_before  = word_valid;
    dac_nsync = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (collide && k == 3) word_ready = 1'b1;
      if (collide && k == 4) word_ready = 1'b0;
      if (lat == 0 && (frame_err || (word_valid && !v_before))) lat = k;
    end
  endtask

  initial begin
    int            lat;
    int            nb;
    logic [31:0]   d;
    int            hits_zero;

    // Reset values while reset is held.
    #23;
    check("rst_word", 32'(word_out), 32'h0);
    check("rst_valid", 32'(word_valid), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_count", 32'(frame_count), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single good frame with ready held high.
    send_frame(32'h3A5C01, 24, 1'b0, lat);
    model_close(24, 32'h3A5C01, 1'b1);
    model_settle(1'b1);
    check("good_latency", 32'(lat), 32'd4);
    compare_state("good");

    // Short and long frames.
    send_frame(32'h2AAAAA, 23, 1'b0, lat);
    model_close(23, 32'h2AAAAA, 1'b1);
    send_frame(32'h1555555, 25, 1'b0, lat);
    model_close(25, 32'h1555555, 1'b1);
    compare_state("shortlong");

    // Back-pressure: second frame is dropped, first is retained.
    word_ready = 1'b0;
    send_frame(32'h000001, 24, 1'b0, lat);
    model_close(24, 32'h000001, 1'b0);
    send_frame(32'h000002, 24, 1'b0, lat);
    model_close(24, 32'h000002, 1'b0);
    compare_state("bp");
    @(posedge clk);
    #1 clr_overflow = 1'b1;
    @(posedge clk);
    #1 clr_overflow = 1'b0;
    m_over = 1'b0;
    check("bp_clr_ovf", 32'(overflow), 32'h0);

    // Handshake and load in the same cycle.
    send_frame(32'hFFFFFF, 24, 1'b1, lat);
    model_close(24, 32'hFFFFFF, 1'b1);
    compare_state("collide");
    word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_settle(1'b1);
    compare_state("drain");

    // Reset in the middle of a frame.
    dac_nsync = 1'b0;
    #40;
    shift_bits(32'h3FF, 10);
    reset_n = 1'b0;
    dac_nsync = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    check("midrst_count", 32'(frame_count), 32'h0);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(32'h123456, 24, 1'b0, lat);
    model_close(24, 32'h123456, 1'b1);
    model_settle(1'b1);
    compare_state("midrst");

    // Randomized frames, mostly well-formed.
    for (int f = 0; f < 20; f++) begin
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(22, 26)) : 24;
      d  = $urandom;
      send_frame(d, nb, 1'b0, lat);
      model_close(nb, d, 1'b1);
      model_settle(1'b1);
      if (nb == 24) check("rand_latency", 32'(lat), 32'd4);
      compare_state("rand");
    end

    // Counter wrap from a fresh reset: 15 frames reach all-ones, the 16th wraps to zero.
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    hits_zero = 0;
    for (int f = 0; f < 16; f++) begin
      d = $urandom;
      send_frame(d, 24, 1'b0, lat);
      model_close(24, d, 1'b1);
      model_settle(1'b1);
      if (f == 14) check("wrap_allones", 32'(frame_count), 32'hF);
    end
    check("wrap_zero", 32'(frame_count), 32'h0);
    compare_state("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
